// File: rtl/sha1_msg_schedule_if.sv
// rtl/sha1_msg_schedule_if.sv - block-in / schedule-word-out handshake bundle for the SHA-1 message scheduler
interface sha1_msg_schedule_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int CHANNEL_NUM_WIDTH = 6
);
    logic                         blk_valid;
    logic                         blk_ready;
    logic [16*DATA_WIDTH-1:0]     blk_data;
    logic [CHANNEL_NUM_WIDTH-1:0] blk_channel;

    logic                         w_valid;
    logic                         w_ready;
    logic [DATA_WIDTH-1:0]        w_data;
    logic [6:0]                   w_round;
    logic [1:0]                   w_func_sel;
    logic [CHANNEL_NUM_WIDTH-1:0] w_channel;
    logic                         w_last;

    // Block producer and round-stage consumer side.
    modport master (
        output blk_valid,
        output blk_data,
        output blk_channel,
        input  blk_ready,
        input  w_valid,
        output w_ready,
        input  w_data,
        input  w_round,
        input  w_func_sel,
        input  w_channel,
        input  w_last
    );

    // Scheduler side.
    modport slave (
        input  blk_valid,
        input  blk_data,
        input  blk_channel,
        output blk_ready,
        output w_valid,
        input  w_ready,
        output w_data,
        output w_round,
        output w_func_sel,
        output w_channel,
        output w_last
    );
endinterface

// File: rtl/sha1_msg_schedule.sv
// rtl/sha1_msg_schedule.sv - SHA-1 message schedule: expands one 512-bit block into W[0..79] over a handshake
module sha1_msg_schedule #(
    parameter int DATA_WIDTH        = 32,
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha1_msg_schedule_if.slave   bus
);

    localparam int         WORDS     = 16;
    localparam logic [6:0] LAST_ROUND = 7'd79;

    if (DATA_WIDTH != 32 || (2 ** CHANNEL_NUM_WIDTH) < CHANNEL_NUM_TOTAL) begin : g_bad_param
        $error("sha1_msg_schedule: unsupported DATA_WIDTH or channel tag too narrow");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state_q,      state_d;
    logic [6:0]                   t_q,          t_d;
    logic                         w_valid_q,    w_valid_d;
    logic [DATA_WIDTH-1:0]        w_data_q,     w_data_d;
    logic [6:0]                   w_round_q,    w_round_d;
    logic [1:0]                   w_func_sel_q, w_func_sel_d;
    logic [CHANNEL_NUM_WIDTH-1:0] w_channel_q,  w_channel_d;
    logic                         w_last_q,     w_last_d;
    logic [DATA_WIDTH-1:0]        sh_q [WORDS];
    logic [DATA_WIDTH-1:0]        sh_d [WORDS];

    logic [DATA_WIDTH-1:0]        sh_mix;
    logic [DATA_WIDTH-1:0]        sh_feedback;
    logic [6:0]                   t_next;
    logic                         accept;
    logic                         advance;

    function automatic logic [1:0] round_group(input logic [6:0] t);
        logic [1:0] g;
        if (t >= 7'd60) begin
            g = 2'd3;
        end else if (t >= 7'd40) begin
            g = 2'd2;
        end else if (t >= 7'd20) begin
            g = 2'd1;
        end else begin
            g = 2'd0;
        end
        return g;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] block_word(input logic [16*DATA_WIDTH-1:0] blk,
                                                         input int k);
        return blk[(WORDS-1-k)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Sliding 16-word window: sh[0] is the word on the output, sh[13]/sh[8]/sh[2]/sh[0]
    // are W[t+13]/W[t+8]/W[t+2]/W[t], which produce W[t+16].
    assign sh_mix      = sh_q[13] ^ sh_q[8] ^ sh_q[2] ^ sh_q[0];
    assign sh_feedback = {sh_mix[DATA_WIDTH-2:0], sh_mix[DATA_WIDTH-1]};
    assign t_next      = t_q + 7'd1;

    assign bus.blk_ready  = (state_q == IDLE) && rst_n;
    assign accept         = bus.blk_valid && (state_q == IDLE);
    assign advance        = w_valid_q && bus.w_ready;

    assign bus.w_valid    = w_valid_q;
    assign bus.w_data     = w_data_q;
    assign bus.w_round    = w_round_q;
    assign bus.w_func_sel = w_func_sel_q;
    assign bus.w_channel  = w_channel_q;
    assign bus.w_last     = w_last_q;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        w_valid_d    = w_valid_q;
        w_data_d     = w_data_q;
        w_round_d    = w_round_q;
        w_func_sel_d = w_func_sel_q;
        w_channel_d  = w_channel_q;
        w_last_d     = w_last_q;
        for (int k = 0; k < WORDS; k++) begin
            sh_d[k] = sh_q[k];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    t_d     = 7'd0;
                    for (int k = 0; k < WORDS; k++) begin
                        sh_d[k] = block_word(bus.blk_data, k);
                    end
                    w_valid_d    = 1'b1;
                    w_data_d     = block_word(bus.blk_data, 0);
                    w_round_d    = 7'd0;
                    w_func_sel_d = 2'd0;
                    w_channel_d  = bus.blk_channel;
                    w_last_d     = 1'b0;
                end
            end

            RUN: begin
                if (advance) begin
                    if (t_q == LAST_ROUND) begin
                        // Drop to IDLE and blank the word so the stale window never shows.
                        state_d      = IDLE;
                        t_d          = 7'd0;
                        w_valid_d    = 1'b0;
                        w_data_d     = '0;
                        w_round_d    = 7'd0;
                        w_func_sel_d = 2'd0;
                        w_last_d     = 1'b0;
                    end else begin
                        for (int k = 0; k < WORDS-1; k++) begin
                            sh_d[k] = sh_q[k+1];
                        end
                        sh_d[WORDS-1] = sh_feedback;
                        t_d           = t_next;
                        w_data_d      = sh_q[1];
                        w_round_d     = t_next;
                        w_func_sel_d  = round_group(t_next);
                        w_last_d      = (t_next == LAST_ROUND);
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                t_d       = 7'd0;
                w_valid_d = 1'b0;
                w_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            t_q          <= 7'd0;
            w_valid_q    <= 1'b0;
            w_data_q     <= '0;
            w_round_q    <= 7'd0;
            w_func_sel_q <= 2'd0;
            w_channel_q  <= '0;
            w_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            w_valid_q    <= w_valid_d;
            w_data_q     <= w_data_d;
            w_round_q    <= w_round_d;
            w_func_sel_q <= w_func_sel_d;
            w_channel_q  <= w_channel_d;
            w_last_q     <= w_last_d;
        end
        // The window is only observable through w_data while w_valid is high.
        sh_q <= sh_d;
    end

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// tb/tb_sha1_msg_schedule.sv - scoreboard bench for sha1_msg_schedule against an array-based SHA-1 schedule model
module tb_sha1_msg_schedule;
    localparam int DW = 32;
    localparam int CT = 64;
    localparam int CW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha1_msg_schedule_if #(.DATA_WIDTH(DW), .CHANNEL_NUM_WIDTH(CW)) bif ();

    sha1_msg_schedule #(
        .DATA_WIDTH(DW),
        .CHANNEL_NUM_TOTAL(CT),
        .CHANNEL_NUM_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [6:0]  round;
        logic [1:0]  fsel;
        logic [5:0]  ch;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          full_ready = 1'b1;
    logic [31:0] obs[80];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: SHA-1 schedule straight from its recurrence over an 80-entry array.
    task automatic push_block(input logic [511:0] blk, input logic [5:0] ch);
        logic [31:0] w[80];
        logic [31:0] x;
        exp_t e;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) begin
                w[t] = blk[511-32*t -: 32];
            end else begin
                x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = (x << 1) | (x >> 31);
            end
            e.data  = w[t];
            e.round = 7'(t);
            e.fsel  = 2'(t / 20);
            e.ch    = ch;
            e.last  = (t == 79);
            sb.push_back(e);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    initial begin
        bif.w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bif.w_ready = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks holds during stalls.
    logic        p_valid, p_ready, p_last;
    logic [31:0] p_data;
    logic [6:0]  p_round;
    logic [1:0]  p_fsel;
    logic [5:0]  p_ch;
    bit          have_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev && p_valid && !p_ready) begin
                    check("stall_hold", {bif.w_valid, bif.w_data, bif.w_round, bif.w_func_sel, bif.w_channel, bif.w_last},
                          {p_valid, p_data, p_round, p_fsel, p_ch, p_last});
                end
                if (bif.w_valid && bif.w_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", {32'd0, bif.w_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("w_data",     64'(bif.w_data),     64'(e.data));
                        check("w_round",    64'(bif.w_round),    64'(e.round));
                        check("w_func_sel", 64'(bif.w_func_sel), 64'(e.fsel));
                        check("w_channel",  64'(bif.w_channel),  64'(e.ch));
                        check("w_last",     64'(bif.w_last),     64'(e.last));
                        if (bif.w_round < 7'd80) obs[bif.w_round] = bif.w_data;
                    end
                end
                p_valid = bif.w_valid;  p_ready = bif.w_ready;  p_data = bif.w_data;
                p_round = bif.w_round;  p_fsel  = bif.w_func_sel; p_ch = bif.w_channel;
                p_last  = bif.w_last;   have_prev = 1'b1;
            end
        end
    end

    task automatic send_block(input logic [511:0] blk, input logic [5:0] ch);
        int n = 0;
        @(negedge clk);
        bif.blk_valid   = 1'b1;
        bif.blk_data    = blk;
        bif.blk_channel = ch;
        while (!bif.blk_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("blk_ready_timeout", 64'(n), 64'd0);
        push_block(blk, ch);
        @(posedge clk);
        #1;
        bif.blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && bif.blk_ready && !bif.w_valid) && n < 1000);
        if (n >= 1000) check("idle_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc;
        logic [511:0] blk;
        int k;

        bif.blk_valid   = 1'b0;
        bif.blk_data    = '0;
        bif.blk_channel = '0;

        repeat (2) @(negedge clk);
        check("rst_blk_ready",  64'(bif.blk_ready),  64'd0);
        check("rst_w_valid",    64'(bif.w_valid),    64'd0);
        check("rst_w_data",     64'(bif.w_data),     64'd0);
        check("rst_w_round",    64'(bif.w_round),    64'd0);
        check("rst_w_func_sel", 64'(bif.w_func_sel), 64'd0);
        check("rst_w_channel",  64'(bif.w_channel),  64'd0);
        check("rst_w_last",     64'(bif.w_last),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_blk_ready", 64'(bif.blk_ready), 64'd1);

        // "abc" padded block
        abc = '0;
        abc[511:480] = 32'h6162_6380;
        abc[31:0]    = 32'h0000_0018;
        for (int i = 0; i < 80; i++) obs[i] = 'x;
        send_block(abc, 6'd5);
        wait_idle();
        check("abc_W0",  64'(obs[0]),  64'h6162_6380);
        check("abc_W15", 64'(obs[15]), 64'h0000_0018);
        check("abc_W16", 64'(obs[16]), 64'hC2C4_C700);
        check("abc_W17", 64'(obs[17]), 64'h0000_0000);
        check("abc_W18", 64'(obs[18]), 64'h0000_0030);

        // Latency and top channel tag with the consumer always ready
        send_block(rand_block(), 6'(CT-1));
        @(negedge clk);
        check("lat_first_valid", 64'(bif.w_valid), 64'd1);
        check("lat_first_round", 64'(bif.w_round), 64'd0);
        k = 0;
        while (!bif.w_last && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("lat_last_offset", 64'(k), 64'd79);
        check("lat_last_round",  64'(bif.w_round), 64'd79);
        @(negedge clk);
        check("lat_ready_after", 64'(bif.blk_ready), 64'd1);
        check("lat_valid_after", 64'(bif.w_valid),   64'd0);
        wait_idle();

        // 100 random blocks with a 50% duty consumer
        full_ready = 1'b0;
        for (int b = 0; b < 100; b++) begin
            send_block(rand_block(), 6'($urandom_range(0, CT-1)));
        end
        wait_idle();
        full_ready = 1'b1;

        // blk_valid held with churning data during RUN
        blk = rand_block();
        @(negedge clk);
        bif.blk_valid   = 1'b1;
        bif.blk_data    = blk;
        bif.blk_channel = 6'd17;
        k = 0;
        while (!bif.blk_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        push_block(blk, 6'd17);
        @(posedge clk);
        #1;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (bif.blk_ready || k >= 500) break;
            bif.blk_data    = rand_block();
            bif.blk_channel = 6'($urandom_range(0, CT-1));
        end
        check("hold_reaccept_gap", 64'(k >= 81), 64'd1);
        push_block(bif.blk_data, bif.blk_channel);
        @(posedge clk);
        #1;
        bif.blk_valid = 1'b0;
        wait_idle();

        // Reset mid-block at round 37
        send_block(rand_block(), 6'd42);
        k = 0;
        while (!(bif.w_valid && bif.w_round == 7'd37) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_round37", 64'(bif.w_round), 64'd37);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_w_valid",   64'(bif.w_valid),   64'd0);
        check("midrst_blk_ready", 64'(bif.blk_ready), 64'd0);
        check("midrst_w_round",   64'(bif.w_round),   64'd0);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_blk_ready", 64'(bif.blk_ready), 64'd1);
        check("after_rst_w_valid",   64'(bif.w_valid),   64'd0);
        for (int i = 0; i < 80; i++) obs[i] = 'x;
        send_block(abc, 6'd3);
        wait_idle();
        check("restart_W0",  64'(obs[0]),  64'h6162_6380);
        check("restart_W16", 64'(obs[16]), 64'hC2C4_C700);
        check("restart_W18", 64'(obs[18]), 64'h0000_0030);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
